// File: rtl/can_pkg.sv
// Shared types and constants for the CAN receive frame sequencer and its destuffer.
package can_pkg;

   typedef enum logic [2:0] {
      F_SOF  = 3'd0,
      F_ID   = 3'd1,
      F_RTR  = 3'd2,
      F_IDE  = 3'd3,
      F_R0   = 3'd4,
      F_DLC  = 3'd5,
      F_DATA = 3'd6
   } field_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_SOF   = 3'd2,
      S_HDR   = 3'd3,
      S_DATA  = 3'd4
   } rx_state_e;

   localparam int HDR_LAST      = 18;
   localparam int MAX_DATA_BITS = 64;
   localparam int STUFF_RUN     = 5;

   function automatic int clks_per_bit(input int clk_mhz, input int kbps);
      return (clk_mhz * 1000) / kbps;
   endfunction

endpackage

// File: rtl/can_bit_destuff.sv
// Bit destuffer: tracks the run of equal sampled bits, drops stuff bits and flags stuff errors.
module can_bit_destuff
   import can_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic smp_bit,
   input  logic smp_valid,
   input  logic clear,
   output logic data_bit,
   output logic data_valid,
   output logic err
);

   logic [2:0] run;
   logic       last;
   logic       stuff_slot;

   // Outputs are combinational so the sequencer can register them with one clock of latency.
   assign stuff_slot = (run == 3'(STUFF_RUN));
   assign data_bit   = smp_bit;
   assign data_valid = smp_valid && !stuff_slot;
   assign err        = smp_valid && stuff_slot && (smp_bit == last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run  <= 3'd0;
         last <= 1'b0;
      end else if (clear) begin
         run  <= 3'd0;
         last <= 1'b0;
      end else if (smp_valid) begin
         if ((run != 3'd0) && !stuff_slot && (smp_bit == last))
            run <= run + 3'd1;
         else
            run <= 3'd1;
         last <= smp_bit;
      end
   end

endmodule

// File: rtl/can_rx_frame_ctrl.sv
// CAN receive frame sequencer: bus-idle qualification, SOF detection, destuffed header capture
// and data-field tracking up to the hand-off to the CRC stage.
module can_rx_frame_ctrl
   import can_pkg::*;
#(
   parameter int CLK_MHZ   = 100,
   parameter int BIT_KBPS  = 1000,
   parameter int IDLE_BITS = 11
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_din,
   input  logic        smp_bit,
   input  logic        smp_valid,
   output logic        sample_en,
   output logic        bit_out,
   output logic        bit_valid,
   output logic [6:0]  bit_idx,
   output field_e      field,
   output logic [10:0] id_out,
   output logic        rtr_out,
   output logic [3:0]  dlc_out,
   output logic        hdr_valid,
   output logic        crc_start,
   output logic        stuff_err,
   output logic        sof_err,
   output logic        fmt_err,
   output rx_state_e   fsm_state
);

   localparam int CPB       = clks_per_bit(CLK_MHZ, BIT_KBPS);
   localparam int IDLE_CLKS = IDLE_BITS * CPB;
   localparam int IW        = $clog2(IDLE_CLKS + 1);

   logic [1:0]    rx_sync;
   logic          rx_prev;
   logic [IW-1:0] idle_cnt;
   logic [10:0]   id_sh;
   logic          rtr_sh;
   logic [2:0]    dlc_sh;
   logic [6:0]    data_last;
   logic          in_frame;
   logic          ds_bit, ds_valid, ds_err;
   logic [6:0]    next_idx;
   logic [3:0]    dlc_new;
   logic [6:0]    n_bits;

   assign in_frame = (fsm_state == S_SOF) || (fsm_state == S_HDR) || (fsm_state == S_DATA);
   assign next_idx = bit_idx + 7'd1;
   assign dlc_new  = {dlc_sh, ds_bit};
   // Data length in bits; DLC values above 8 still mean 8 bytes.
   assign n_bits   = rtr_sh ? 7'd0 :
                     (dlc_new > 4'd8) ? 7'(MAX_DATA_BITS) : {dlc_new, 3'b000};

   can_bit_destuff u_destuff (
      .clk        (clk),
      .rst        (rst),
      .smp_bit    (smp_bit),
      .smp_valid  (smp_valid && in_frame),
      .clear      (!in_frame),
      .data_bit   (ds_bit),
      .data_valid (ds_valid),
      .err        (ds_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync <= 2'b00;
         rx_prev <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], rx_din};
         rx_prev <= rx_sync[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_state <= S_IDLE;
         idle_cnt  <= '0;
         sample_en <= 1'b0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         bit_idx   <= 7'd0;
         field     <= F_SOF;
         id_out    <= 11'd0;
         rtr_out   <= 1'b0;
         dlc_out   <= 4'd0;
         hdr_valid <= 1'b0;
         crc_start <= 1'b0;
         stuff_err <= 1'b0;
         sof_err   <= 1'b0;
         fmt_err   <= 1'b0;
         id_sh     <= 11'd0;
         rtr_sh    <= 1'b0;
         dlc_sh    <= 3'd0;
         data_last <= 7'd0;
      end else begin
         bit_valid <= 1'b0;
         hdr_valid <= 1'b0;
         crc_start <= 1'b0;
         stuff_err <= 1'b0;
         sof_err   <= 1'b0;
         fmt_err   <= 1'b0;
         case (fsm_state)
            S_IDLE: begin
               sample_en <= 1'b0;
               if (!rx_sync[1])
                  idle_cnt <= '0;
               else if (idle_cnt == IW'(IDLE_CLKS - 1)) begin
                  idle_cnt  <= '0;
                  fsm_state <= S_ARMED;
               end else
                  idle_cnt <= idle_cnt + IW'(1);
            end
            S_ARMED: begin
               if (rx_prev && !rx_sync[1]) begin
                  sample_en <= 1'b1;
                  fsm_state <= S_SOF;
               end
            end
            default: begin
               // A stuff violation wins over whatever field the bit would have belonged to.
               if (ds_err) begin
                  stuff_err <= 1'b1;
                  fsm_state <= S_IDLE;
               end else if (ds_valid) begin
                  if (fsm_state == S_SOF) begin
                     if (!ds_bit) begin
                        bit_valid <= 1'b1;
                        bit_out   <= 1'b0;
                        bit_idx   <= 7'd0;
                        field     <= F_SOF;
                        fsm_state <= S_HDR;
                     end else begin
                        sof_err   <= 1'b1;
                        fsm_state <= S_IDLE;
                     end
                  end else if (fsm_state == S_HDR) begin
                     bit_out <= ds_bit;
                     bit_idx <= next_idx;
                     if (next_idx <= 7'd11) begin
                        bit_valid <= 1'b1;
                        field     <= F_ID;
                        id_sh     <= {id_sh[9:0], ds_bit};
                     end else if (next_idx == 7'd12) begin
                        bit_valid <= 1'b1;
                        field     <= F_RTR;
                        rtr_sh    <= ds_bit;
                     end else if (next_idx == 7'd13) begin
                        if (ds_bit) begin
                           fmt_err   <= 1'b1;
                           fsm_state <= S_IDLE;
                        end else begin
                           bit_valid <= 1'b1;
                           field     <= F_IDE;
                        end
                     end else if (next_idx == 7'd14) begin
                        bit_valid <= 1'b1;
                        field     <= F_R0;
                     end else begin
                        bit_valid <= 1'b1;
                        field     <= F_DLC;
                        dlc_sh    <= {dlc_sh[1:0], ds_bit};
                        if (next_idx == 7'(HDR_LAST)) begin
                           hdr_valid <= 1'b1;
                           id_out    <= id_sh;
                           rtr_out   <= rtr_sh;
                           dlc_out   <= dlc_new;
                           data_last <= 7'(HDR_LAST) + n_bits;
                           if (n_bits == 7'd0) begin
                              crc_start <= 1'b1;
                              fsm_state <= S_IDLE;
                           end else
                              fsm_state <= S_DATA;
                        end
                     end
                  end else begin
                     bit_valid <= 1'b1;
                     bit_out   <= ds_bit;
                     bit_idx   <= next_idx;
                     field     <= F_DATA;
                     if (next_idx == data_last) begin
                        crc_start <= 1'b1;
                        fsm_state <= S_IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_can_rx_frame_ctrl.sv
// Bench for can_rx_frame_ctrl: builds stuffed CAN frames from field values and compares the
// destuffed bit stream, header capture and control pulses against a frame-level model.
`timescale 1ns/1ps
module tb_can_rx_frame_ctrl;
   import can_pkg::*;

   localparam int CLK_MHZ   = 100;
   localparam int BIT_KBPS  = 10000;
   localparam int IDLE_BITS = 11;
   localparam int CPB       = CLK_MHZ * 1000 / BIT_KBPS;
   localparam int EW        = 13;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst, rx_din, smp_bit, smp_valid;
   logic        sample_en, bit_out, bit_valid;
   logic [6:0]  bit_idx;
   field_e      field;
   logic [10:0] id_out;
   logic        rtr_out;
   logic [3:0]  dlc_out;
   logic        hdr_valid, crc_start, stuff_err, sof_err, fmt_err;
   rx_state_e   fsm_state;

   always #5 clk = ~clk;

   can_rx_frame_ctrl #(.CLK_MHZ(CLK_MHZ), .BIT_KBPS(BIT_KBPS), .IDLE_BITS(IDLE_BITS)) dut (
      .clk(clk), .rst(rst), .rx_din(rx_din), .smp_bit(smp_bit), .smp_valid(smp_valid),
      .sample_en(sample_en), .bit_out(bit_out), .bit_valid(bit_valid), .bit_idx(bit_idx),
      .field(field), .id_out(id_out), .rtr_out(rtr_out), .dlc_out(dlc_out),
      .hdr_valid(hdr_valid), .crc_start(crc_start), .stuff_err(stuff_err),
      .sof_err(sof_err), .fmt_err(fmt_err), .fsm_state(fsm_state)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor: {idx, field, bit, hdr_valid, crc_start} per bit_valid ----------------
   logic [EW-1:0] obs_q[$];
   logic [EW-1:0] exp_q[$];
   int   hdr_cnt, crc_cnt, stuff_cnt, sof_cnt, fmt_cnt, rise_cnt;
   int   pulse_cyc, rise_cyc, fall_cyc, sof_fall_cyc;
   logic se_prev = 1'b0;
   bit   mark = 1'b0;

   always @(negedge clk) begin
      if (bit_valid) obs_q.push_back({bit_idx, field, bit_out, hdr_valid, crc_start});
      if (hdr_valid) hdr_cnt++;
      if (crc_start) begin crc_cnt++; pulse_cyc = cyc; end
      if (stuff_err) begin stuff_cnt++; pulse_cyc = cyc; end
      if (sof_err) begin sof_cnt++; pulse_cyc = cyc; end
      if (fmt_err) begin fmt_cnt++; pulse_cyc = cyc; end
      if (sample_en && !se_prev) begin rise_cnt++; rise_cyc = cyc; end
      if (!sample_en && se_prev) fall_cyc = cyc;
      se_prev = sample_en;
   end

   // ---------------- frame model ----------------
   logic [10:0] m_id;
   logic        m_rtr;
   logic [3:0]  m_dlc;
   int          m_n;

   function automatic logic [2:0] field_of(input int i);
      if (i == 0) return 3'd0;
      if (i <= 11) return 3'd1;
      if (i == 12) return 3'd2;
      if (i == 13) return 3'd3;
      if (i == 14) return 3'd4;
      if (i <= 18) return 3'd5;
      return 3'd6;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      obs_q.delete();
      hdr_cnt = 0; crc_cnt = 0; stuff_cnt = 0; sof_cnt = 0; fmt_cnt = 0; rise_cnt = 0;
      pulse_cyc = -100; rise_cyc = -100; fall_cyc = -100; sof_fall_cyc = -100;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic lvl, input logic smp, input logic sval);
      for (int c = 0; c < CPB; c++) begin
         @(posedge clk); #1;
         if (mark && c == 0 && !lvl) begin sof_fall_cyc = cyc; mark = 1'b0; end
         rx_din    = lvl;
         smp_bit   = sval;
         smp_valid = smp && (c == CPB / 2);
      end
   endtask

   task automatic mid_reset();
      check("pre_reset_state", fsm_state, S_DATA);
      rst = 1'b1;
      #1;
      check("mid_reset_outputs", {sample_en, bit_out, bit_valid, bit_idx, field, id_out, rtr_out,
                                  dlc_out, hdr_valid, crc_start, stuff_err, sof_err, fmt_err}, 0);
      check("mid_reset_state", fsm_state, S_IDLE);
      smp_valid = 1'b0;
      rx_din    = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_frame(input logic [10:0] id, input logic rtr, input logic ide,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input bit do_stuff, input int abort_at);
      logic raw[$];
      logic tx[$];
      int   run;
      logic last;
      int   n;
      n = rtr ? 0 : 8 * ((dlc > 4'd8) ? 8 : int'(dlc));
      raw.push_back(1'b0);
      for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rtr);
      raw.push_back(ide);
      raw.push_back(1'b0);
      for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
      for (int i = 0; i < n; i++) raw.push_back(data[63 - i]);
      exp_q.delete();
      for (int i = 0; i < raw.size(); i++)
         exp_q.push_back({7'(i), field_of(i), raw[i], 1'(i == 18), 1'(i == 18 + n)});
      // Transmitter rule: after five equal bits insert one of the opposite polarity.
      run = 0;
      last = 1'b1;
      foreach (raw[i]) begin
         tx.push_back(raw[i]);
         if (do_stuff) begin
            if (run > 0 && raw[i] == last) run++;
            else begin run = 1; last = raw[i]; end
            if (run == 5) begin tx.push_back(!last); last = !last; run = 1; end
         end
      end
      m_id = id; m_rtr = rtr; m_dlc = dlc; m_n = n;
      for (int i = 0; i < IDLE_BITS + 2; i++) drive_bit(1'b1, 1'b0, 1'b1);
      mark = 1'b1;
      for (int k = 0; k < tx.size(); k++) begin
         if (k == abort_at) begin
            mid_reset();
            return;
         end
         drive_bit(tx[k], 1'b1, tx[k]);
      end
      for (int i = 0; i < 7; i++) begin
         logic b;
         b = 1'($urandom_range(0, 1));
         drive_bit(b, 1'b1, b);
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_events(input string tag, input int upto);
      for (int i = 0; i < upto && i < obs_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s ev%0d", tag, i), obs_q[i], exp_q[i]);
   endtask

   task automatic check_frame(input string tag);
      check({tag, " ev_count"}, obs_q.size(), exp_q.size());
      check_events(tag, exp_q.size());
      check({tag, " hdr_cnt"}, hdr_cnt, 1);
      check({tag, " crc_cnt"}, crc_cnt, 1);
      check({tag, " err_cnt"}, stuff_cnt + sof_cnt + fmt_cnt, 0);
      check({tag, " id_out"}, id_out, m_id);
      check({tag, " rtr_out"}, rtr_out, m_rtr);
      check({tag, " dlc_out"}, dlc_out, m_dlc);
      check({tag, " en_rise_lat"}, rise_cyc - sof_fall_cyc, 3);
      check({tag, " en_fall_lat"}, fall_cyc - pulse_cyc, 1);
      check({tag, " state"}, fsm_state, S_IDLE);
   endtask

   // ---------------- directed / random sequence ----------------
   initial begin
      logic [10:0] prev_id;
      logic [7:0]  data_b;
      int          nd;
      logic [6:0]  crc_idx;

      rst = 1'b1; rx_din = 1'b1; smp_bit = 1'b1; smp_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {sample_en, bit_out, bit_valid, bit_idx, field, id_out, rtr_out,
                              dlc_out, hdr_valid, crc_start, stuff_err, sof_err, fmt_err}, 0);
      check("reset_state", fsm_state, S_IDLE);
      rst = 1'b0;

      // Normal data frame: ID 0x123, DLC 1, data 0xA5.
      clear_mon();
      send_frame(11'h123, 1'b0, 1'b0, 4'd1, {8'hA5, 56'd0}, 1'b1, -1);
      check_frame("normal");
      data_b = 8'd0; nd = 0; crc_idx = 7'd0;
      foreach (obs_q[i]) begin
         if (obs_q[i][5:3] == 3'd6) begin data_b = {data_b[6:0], obs_q[i][2]}; nd++; end
         if (obs_q[i][0]) crc_idx = obs_q[i][12:6];
      end
      check("normal data_count", nd, 8);
      check("normal data_byte", data_b, 8'hA5);
      check("normal crc_idx", crc_idx, 26);

      // Stuff error: ID 0 sent without stuff bits.
      prev_id = m_id;
      clear_mon();
      send_frame(11'h000, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0, -1);
      check("stuff err_cnt", stuff_cnt, 1);
      check("stuff other_err", sof_cnt + fmt_cnt, 0);
      check("stuff hdr_cnt", hdr_cnt, 0);
      check("stuff ev_count", obs_q.size(), 5);
      check_events("stuff", 5);
      check("stuff en_fall_lat", fall_cyc - pulse_cyc, 1);
      check("stuff state", fsm_state, S_IDLE);
      check("stuff sample_en", sample_en, 0);
      check("stuff id_hold", id_out, prev_id);

      // Falling edge after only five recessive bits must not start a frame.
      clear_mon();
      drive_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) drive_bit(1'b1, 1'b1, 1'b1);
      check("early en_rise", rise_cnt, 0);
      check("early ev_count", obs_q.size(), 0);
      check("early state", fsm_state, S_IDLE);
      clear_mon();
      send_frame(11'($urandom), 1'b0, 1'b0, 4'($urandom_range(0, 8)),
                 {$urandom, $urandom}, 1'b1, -1);
      check_frame("after_early");

      // Remote frame: header and CRC hand-off in the same cycle.
      clear_mon();
      send_frame(11'($urandom), 1'b1, 1'b0, 4'd4, {$urandom, $urandom}, 1'b1, -1);
      check_frame("remote");
      check("remote last_ev_hdr_crc", (obs_q.size() > 0) ? obs_q[obs_q.size() - 1][1:0] : 2'b00, 2'b11);

      // DLC above 8 clamps to 64 data bits.
      clear_mon();
      send_frame(11'($urandom), 1'b0, 1'b0, 4'd15, {$urandom, $urandom}, 1'b1, -1);
      check_frame("dlc15");
      check("dlc15 ev_count", obs_q.size(), 83);

      // SOF error: edge seen but the sampler reports recessive.
      clear_mon();
      for (int i = 0; i < IDLE_BITS + 2; i++) drive_bit(1'b1, 1'b0, 1'b1);
      drive_bit(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b1, 1'b1);
      check("sof err_cnt", sof_cnt, 1);
      check("sof en_rise", rise_cnt, 1);
      check("sof ev_count", obs_q.size(), 0);
      check("sof en_fall_lat", fall_cyc - pulse_cyc, 1);

      // IDE=1 (extended frame) is a format error and leaves the header registers alone.
      prev_id = id_out;
      clear_mon();
      send_frame(11'($urandom), 1'b0, 1'b1, 4'd2, {$urandom, $urandom}, 1'b1, -1);
      check("fmt err_cnt", fmt_cnt, 1);
      check("fmt other_err", sof_cnt + stuff_cnt, 0);
      check("fmt hdr_cnt", hdr_cnt, 0);
      check("fmt ev_prefix", obs_q.size() >= 13, 1);
      check_events("fmt", 13);
      check("fmt en_fall_lat", fall_cyc - pulse_cyc, 1);
      check("fmt id_hold", id_out, prev_id);

      // Reset during DATA, then a clean frame.
      clear_mon();
      send_frame(11'($urandom), 1'b0, 1'b0, 4'd8, {$urandom, $urandom}, 1'b1, 35);
      clear_mon();
      send_frame(11'($urandom), 1'b0, 1'b0, 4'($urandom_range(1, 15)),
                 {$urandom, $urandom}, 1'b1, -1);
      check_frame("post_reset");

      // Randomized frames.
      for (int f = 0; f < 4; f++) begin
         clear_mon();
         send_frame(11'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0,
                    4'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b1, -1);
         check_frame($sformatf("rand%0d", f));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/can_rx_frame_ctrl.md
# can_rx_frame_ctrl

Frame-level sequencer for the CAN receive sampler (`can_rx_sample`). It performs these steps in order:
- Qualifies bus idle, detects the SOF falling edge, and drives the sampler's `en`.
- Consumes the sampler's `dout`/`dvalid` stream, removes stuff bits, and tracks the frame field.
- Captures ID, RTR and DLC.
- Drops `en` at the start of the CRC field, handing off to the CRC stage.

It supports standard (11-bit ID) frames only.

## Interface
- `CLK_MHZ`, 100: system clock frequency.
- `BIT_KBPS`, 1000: CAN bit rate. `CPB = CLK_MHZ*1000/BIT_KBPS` clocks per bit.
- `IDLE_BITS`, 11: number of recessive bit times required before a falling edge is accepted as SOF.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_din` in 1: raw CAN rx line, also wired to the sampler's `din`.
- `smp_bit` in 1: sampler `dout`.
- `smp_valid` in 1: sampler `dvalid`, a 1-cycle pulse.
- `sample_en` out 1: drives the sampler's `en`.
- `bit_out` out 1: destuffed bit.
- `bit_valid` out 1: 1-cycle pulse qualifying `bit_out`.
- `bit_idx` out 7: destuffed bit index. SOF is index 0.
- `field` out 3: field of the current `bit_out`. Codes: SOF=0, ID=1, RTR=2, IDE=3, R0=4, DLC=5, DATA=6.
- `id_out` out 11: captured ID, MSB first.
- `rtr_out` out 1: captured RTR bit.
- `dlc_out` out 4: captured DLC.
- `hdr_valid` out 1: pulses when the last DLC bit is accepted.
- `crc_start` out 1: pulses when the data field completes.
- `stuff_err` out 1: pulse.
- `sof_err` out 1: pulse.
- `fmt_err` out 1: pulse.

## Operation
- `rx_din` passes through a 2-FF synchronizer. Edge detection and the idle counter use the synchronized copy.

State machine:
- **IDLE**
  - The idle counter increments while the synchronized rx is 1 and clears on any 0.
  - When it reaches `IDLE_BITS*CPB`, go to ARMED.
- **ARMED**
  - A synchronized 1→0 transition sets `sample_en`=1 and moves to SOF.
- **SOF**
  - First `smp_valid` with `smp_bit`=0: emit as index 0, field SOF, then go to HDR.
  - First `smp_valid` with `smp_bit`=1: pulse `sof_err`, then go to IDLE.
- **HDR**, destuffed indices 1–18:
  - 1–11 form the ID, shifted MSB first.
  - 12 is RTR, 13 is IDE, 14 is R0, 15–18 form the DLC.
  - IDE=1: pulse `fmt_err`, go to IDLE.
  - After index 18: pulse `hdr_valid`. Compute `N = rtr ? 0 : 8*min(DLC,8)`.
  - If N=0, pulse `crc_start` and go to IDLE. Otherwise go to DATA.
- **DATA**
  - Emit N bits, with field DATA.
  - After the bit at index 18+N, pulse `crc_start` and go to IDLE.
- On every return to IDLE, `sample_en` goes to 0 and the idle counter restarts. EOF/IFS then re-qualifies the bus for the next frame.

Destuffing:
- The run counter counts consecutive equal sampled bits, including SOF and stuff bits.
- After a run of 5, the next `smp_valid` is a stuff bit:
  - If it is the opposite polarity, discard it (no `bit_valid`, `bit_idx` unchanged) and set the run to 1 with the new polarity.
  - If it is the same polarity, pulse `stuff_err` and go to IDLE.
- Destuffing covers SOF through the last data bit.

Other rules:
- The three error pulses are mutually exclusive. Each forces `sample_en`=0 in the cycle after the pulse.
- `id_out`, `rtr_out` and `dlc_out` hold until overwritten by the next frame's header. They clear only on reset.
- `smp_valid` is ignored outside SOF/HDR/DATA.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Asserting `rst` mid-frame takes effect immediately, asynchronously, from any state.
- `sample_en` rises 3 clocks after the raw `rx_din` falling edge: 2 sync stages plus 1 register.
- `bit_valid` and `bit_out` rise 1 clock after the accepted `smp_valid`.
- `hdr_valid` coincides with `bit_valid` for index 18.
- `crc_start` coincides with `bit_valid` of the last data bit, or with `hdr_valid` when N=0.
- `sample_en` falls 1 clock after `crc_start` or after any error pulse.
- Error pulses come 1 clock after the offending `smp_valid`.
- `bit_idx` width of 7 bits covers a maximum of 18+64=82.
- Simultaneous events:
  - A stuff bit never produces `bit_valid`.
  - A stuff error takes precedence over field processing in the same cycle.

## Structure
- Package `can_pkg` holds:
  - the field enum and state enum;
  - `HDR_LAST=18` and `MAX_DATA_BITS=64`;
  - a `clks_per_bit(clk_mhz, kbps)` function.
- Sub-module `can_bit_destuff` contains the run counter, stuff detection and stuff error. It has inputs `bit`, `valid` and `clear`, and outputs `bit`, `valid` and `err`.
- The top level holds the FSM, the idle counter, the synchronizer and the header capture.

## Test plan
- **Normal data frame.** After 11 idle bits, send a frame with ID 0x123, RTR=0, DLC=1, data 0xA5, including correct stuff bits.
  - `id_out`=0x123 and `dlc_out`=1, with `hdr_valid` at index 18.
  - 8 DATA `bit_valid` pulses equal to 10100101.
  - `crc_start` at index 26, and `sample_en` low 1 clock later.
- **Stuff error.** Send ID 0x000, producing 6 consecutive dominant bits with no stuff bit.
  - `stuff_err` pulse, `sample_en`=0, state IDLE.
  - No `hdr_valid`.
- **Falling edge before idle qualifies.** Drop rx after only 5 recessive bit times.
  - `sample_en` stays 0.
  - A later edge after 11 idle bits is accepted.
- **Remote frame.** Send RTR=1, DLC=4.
  - `hdr_valid` and `crc_start` pulse in the same cycle.
  - No DATA bits.
- **DLC clamping.** Send DLC=15.
  - `dlc_out`=15.
  - Exactly 64 DATA bits, with `crc_start` at index 82.
- **Reset mid-frame.** Assert `rst` during the DATA field.
  - All outputs are 0 immediately.
  - After release, the next frame decodes correctly.
